// File: rtl/baud_tick_gen_pkg.sv
// Shared constants and parameter checks for the baud tick generator and related clock dividers.
package baud_tick_gen_pkg;

   localparam int DIV_MIN = 32'sd2;

   function automatic bit os_valid(input int os);
      return (os >= 32'sd4) && ((os & (os - 32'sd1)) == 32'sd0);
   endfunction

endpackage

// File: rtl/baud_tick_gen_frac_acc.sv
// Fractional period accumulator: turns an int.frac divisor into a sequence of integer
// period lengths whose running average equals the divisor.
module baud_tick_gen_frac_acc
   import baud_tick_gen_pkg::*;
#(
   parameter int N       = 16,
   parameter int F       = 4,
   parameter int DIV_RST = 326
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         restart,
   input  logic         step,
   input  logic [N-1:0] div_int,
   input  logic [F-1:0] div_frac,
   output logic [N:0]   period
);

   logic [F-1:0] acc;
   logic [F-1:0] base;
   logic [F:0]   sum;
   logic [N:0]   next_period;

   // length of the period that starts now; a restart drops the accumulated phase first
   always_comb begin
      base        = {F{1'b0}};
      sum         = {(F+1){1'b0}};
      next_period = {(N+1){1'b0}};
      if (restart) begin
         base = {F{1'b0}};
      end else begin
         base = acc;
      end
      sum         = {1'b0, base} + {1'b0, div_frac};
      // N+1 bits so that the largest divisor plus a carry still fits
      next_period = {1'b0, div_int} + {{N{1'b0}}, sum[F]};
   end

   // accumulator and current period length, updated only at period starts
   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= {F{1'b0}};
         period <= (N+1)'(DIV_RST);
      end else if (restart || step) begin
         acc    <= sum[F-1:0];
         period <= next_period;
      end
   end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable fractional baud tick generator: oversample, bit and mid-bit ticks with
// run-time divisor loading, enable and phase re-synchronisation.
module baud_tick_gen
   import baud_tick_gen_pkg::*;
#(
   parameter int N        = 16,
   parameter int F        = 4,
   parameter int OS       = 16,
   parameter int DIV_RST  = 326,
   parameter int FRAC_RST = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  sync,
   input  logic                  div_load,
   input  logic [N-1:0]          div_int,
   input  logic [F-1:0]          div_frac,
   output logic                  os_tick,
   output logic                  bit_tick,
   output logic                  mid_tick,
   output logic                  div_err,
   output logic [N-1:0]          q,
   output logic [$clog2(OS)-1:0] os_cnt
);

   localparam int               OSW        = $clog2(OS);
   localparam logic [N-1:0]     DIV_MIN_V  = N'(DIV_MIN);
   localparam logic [N-1:0]     Q_ONE      = N'(1);
   localparam logic [N:0]       PERIOD_ONE = (N+1)'(1);
   localparam logic [OSW-1:0]   OS_ONE     = OSW'(1);
   localparam logic [OSW-1:0]   OS_LAST    = OSW'(OS - 1);
   localparam logic [OSW-1:0]   OS_MID     = OSW'(OS / 2 - 1);

   if (!os_valid(OS) || (DIV_RST < DIV_MIN) || ((DIV_RST >> N) != 32'sd0)) begin : g_bad_param
      $error("baud_tick_gen: OS must be a power of two >= 4 and DIV_RST must fit N bits and be >= 2");
   end

   logic [N-1:0] act_int;
   logic [F-1:0] act_frac;
   logic [N-1:0] pend_int;
   logic [F-1:0] pend_frac;
   logic         pend_v;
   logic [N:0]   period;

   logic         wrap;
   logic         step;
   logic         take_pend;
   logic         load_ok;
   logic         load_bad;
   logic [N-1:0] eff_int;
   logic [F-1:0] eff_frac;

   // wrap detection, shadow hand-over and load qualification
   always_comb begin
      wrap      = 1'b0;
      step      = 1'b0;
      take_pend = 1'b0;
      load_ok   = 1'b0;
      load_bad  = 1'b0;
      eff_int   = act_int;
      eff_frac  = act_frac;
      wrap      = en && ({1'b0, q} == (period - PERIOD_ONE));
      step      = wrap && !sync;
      load_bad  = div_load && (div_int < DIV_MIN_V);
      load_ok   = div_load && !load_bad;
      // a disabled generator has no period start to wait for, so the shadow moves at once
      take_pend = pend_v && (sync || wrap || !en);
      if (take_pend) begin
         eff_int  = pend_int;
         eff_frac = pend_frac;
      end else begin
         eff_int  = act_int;
         eff_frac = act_frac;
      end
   end

   // active divisor, pending shadow and load error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         act_int   <= N'(DIV_RST);
         act_frac  <= F'(FRAC_RST);
         pend_int  <= {N{1'b0}};
         pend_frac <= {F{1'b0}};
         pend_v    <= 1'b0;
         div_err   <= 1'b0;
      end else begin
         div_err <= load_bad;
         if (take_pend) begin
            act_int  <= pend_int;
            act_frac <= pend_frac;
            pend_v   <= 1'b0;
         end
         // a load landing with a hand-over refills the shadow for the following start
         if (load_ok) begin
            pend_int  <= div_int;
            pend_frac <= div_frac;
            pend_v    <= 1'b1;
         end
      end
   end

   baud_tick_gen_frac_acc #(
      .N       (N),
      .F       (F),
      .DIV_RST (DIV_RST)
   ) u_frac_acc (
      .clk      (clk),
      .reset    (reset),
      .restart  (sync),
      .step     (step),
      .div_int  (eff_int),
      .div_frac (eff_frac),
      .period   (period)
   );

   // period counter, oversample index and registered ticks
   always_ff @(posedge clk) begin
      if (reset) begin
         q        <= {N{1'b0}};
         os_cnt   <= {OSW{1'b0}};
         os_tick  <= 1'b0;
         bit_tick <= 1'b0;
         mid_tick <= 1'b0;
      end else if (sync) begin
         q        <= {N{1'b0}};
         os_cnt   <= {OSW{1'b0}};
         os_tick  <= 1'b0;
         bit_tick <= 1'b0;
         mid_tick <= 1'b0;
      end else if (wrap) begin
         q        <= {N{1'b0}};
         os_cnt   <= os_cnt + OS_ONE;
         os_tick  <= 1'b1;
         bit_tick <= (os_cnt == OS_LAST);
         mid_tick <= (os_cnt == OS_MID);
      end else begin
         if (en) begin
            q <= q + Q_ONE;
         end
         os_tick  <= 1'b0;
         bit_tick <= 1'b0;
         mid_tick <= 1'b0;
      end
   end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios plus random traffic, checked every
// cycle against a closed-form tick schedule (tick k at k*int + floor((a0 + k*frac)/2^F)).
module tb_baud_tick_gen;

   localparam int N       = 16;
   localparam int F       = 4;
   localparam int OS      = 16;
   localparam int DIV_RST = 326;
   localparam int FD      = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic         sync;
   logic         div_load;
   logic [N-1:0] div_int;
   logic [F-1:0] div_frac;
   logic         os_tick;
   logic         bit_tick;
   logic         mid_tick;
   logic         div_err;
   logic [N-1:0] q;
   logic [3:0]   os_cnt;

   always #5 clk = ~clk;

   baud_tick_gen #(
      .N(N), .F(F), .OS(OS), .DIV_RST(DIV_RST), .FRAC_RST(0)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .sync(sync), .div_load(div_load),
      .div_int(div_int), .div_frac(div_frac), .os_tick(os_tick), .bit_tick(bit_tick),
      .mid_tick(mid_tick), .div_err(div_err), .q(q), .os_cnt(os_cnt)
   );

   int total   = 0;
   int bad     = 0;
   int err_cnt = 0;

   // reference: a segment is a run of periods with one divisor, starting at phase seg_p0
   int m_p = 0;
   int seg_p0 = 0, seg_i = DIV_RST, seg_f = 0, seg_a0 = 0, seg_k0 = 0;
   bit m_pend_v = 1'b0;
   int m_pend_i = 0, m_pend_f = 0;
   bit e_tick = 1'b0, e_bit = 1'b0, e_mid = 1'b0, e_err = 1'b0;
   int e_q = 0, e_os = 0;

   function automatic int t_of(input int k);
      return seg_p0 + k * seg_i + (seg_a0 + k * seg_f) / FD;
   endfunction

   function automatic int k_at(input int p);
      int k = 0;
      while (t_of(k + 1) <= p) k++;
      return k;
   endfunction

   function automatic int next_gap();
      return t_of(k_at(m_p) + 1) - m_p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int k;
      bit hit;
      hit = 1'b0;
      if (reset) begin
         m_p = 0; seg_p0 = 0; seg_i = DIV_RST; seg_f = 0; seg_a0 = 0; seg_k0 = 0;
         m_pend_v = 1'b0;
         e_err = 1'b0;
      end else begin
         if (sync) begin
            if (m_pend_v) begin
               seg_i = m_pend_i; seg_f = m_pend_f; m_pend_v = 1'b0;
            end
            m_p = 0; seg_p0 = 0; seg_a0 = 0; seg_k0 = 0;
         end else if (en) begin
            m_p++;
            k = k_at(m_p);
            hit = (k > 0) && (t_of(k) == m_p);
            if (hit && m_pend_v) begin
               seg_a0 = (seg_a0 + k * seg_f) % FD;
               seg_k0 = seg_k0 + k;
               seg_p0 = m_p;
               seg_i = m_pend_i; seg_f = m_pend_f; m_pend_v = 1'b0;
            end
         end
         e_err = div_load && (int'(div_int) < 2);
         if (div_load && int'(div_int) >= 2) begin
            m_pend_i = int'(div_int); m_pend_f = int'(div_frac); m_pend_v = 1'b1;
         end
      end
      k = k_at(m_p);
      e_q = m_p - t_of(k);
      e_os = (seg_k0 + k) % OS;
      e_tick = hit;
      e_bit = hit && (e_os == 0);
      e_mid = hit && (e_os == OS / 2);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      if (div_err === 1'b1) err_cnt++;
      chk("q", q, e_q);
      chk("os_cnt", os_cnt, e_os);
      chk("os_tick", os_tick, e_tick);
      chk("bit_tick", bit_tick, e_bit);
      chk("mid_tick", mid_tick, e_mid);
      chk("div_err", div_err, e_err);
   endtask

   task automatic wait_tick(input int budget, output int n);
      n = 0;
      do begin
         cyc();
         n++;
         div_load = 1'b0;
         sync = 1'b0;
      end while (os_tick !== 1'b1 && n < budget);
      chk("tick_timeout", os_tick, 1);
   endtask

   initial begin
      int n, sum;
      reset = 1'b1; en = 1'b0; sync = 1'b0; div_load = 1'b0;
      div_int = '0; div_frac = '0;
      repeat (3) cyc();
      chk("reset_q", q, 0);
      chk("reset_os_tick", os_tick, 0);

      // defaults: 326-cycle oversample, bit tick every 16, mid tick at index 8
      reset = 1'b0; en = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         wait_tick(400, n);
         chk("default_gap", n, DIV_RST);
         if (i % 16 == 0) chk("bit_tick_16th", bit_tick, 1);
         if (i % 16 == 8) chk("mid_tick_8th", mid_tick, 1);
      end

      // 10 + 8/16 divisor after sync: 10, 11, 10, 11 ...
      div_int = 16'd10; div_frac = 4'd8; div_load = 1'b1; cyc(); div_load = 1'b0;
      sync = 1'b1; cyc(); sync = 1'b0;
      sum = 0;
      for (int i = 0; i < 32; i++) begin
         wait_tick(20, n);
         chk("frac_gap", n, (i % 2 == 0) ? 10 : 11);
         sum += n;
      end
      chk("frac_sum32", sum, 336);

      // rejected load leaves the spacing alone
      div_int = N'($urandom_range(0, 1)); div_frac = F'($urandom_range(0, 15)); div_load = 1'b1;
      wait_tick(20, n);
      chk("err_gap_a", n, 10);
      wait_tick(20, n);
      chk("err_gap_b", n, 11);
      chk("div_err_count", err_cnt, 1);

      // sync on the wrap cycle suppresses that tick
      n = 0;
      while (next_gap() != 1 && n < 40) begin cyc(); n++; end
      sync = 1'b1; cyc(); sync = 1'b0;
      chk("sync_wrap_no_tick", os_tick, 0);
      chk("sync_wrap_os_cnt", os_cnt, 0);
      wait_tick(20, n);
      chk("sync_wrap_gap", n, 10);

      // freeze at q=100 for 50 cycles
      div_int = 16'd200; div_frac = 4'd0; div_load = 1'b1; cyc(); div_load = 1'b0;
      sync = 1'b1; cyc(); sync = 1'b0;
      n = 0;
      while (e_q != 100 && n < 300) begin cyc(); n++; end
      en = 1'b0;
      repeat (50) cyc();
      chk("en_frozen_q", q, 100);
      en = 1'b1;
      wait_tick(300, n);
      chk("en_resume_gap", n, 100);
      for (int i = 0; i < 300; i++) begin
         en = ($urandom_range(0, 3) != 0);
         cyc();
      end
      en = 1'b1;

      // load 20 at q=5 of a 326 period: current period completes first
      div_int = 16'd326; div_frac = 4'd0; div_load = 1'b1; cyc(); div_load = 1'b0;
      sync = 1'b1; cyc(); sync = 1'b0;
      n = 0;
      while (e_q != 5 && n < 20) begin cyc(); n++; end
      div_int = 16'd20; div_frac = 4'd0; div_load = 1'b1;
      wait_tick(400, n);
      chk("load20_finish", n, 326 - 5);
      wait_tick(40, n);
      chk("load20_gap_a", n, 20);
      wait_tick(40, n);
      chk("load20_gap_b", n, 20);

      // reset mid-period overrides a simultaneous sync and load
      repeat ($urandom_range(3, 15)) cyc();
      reset = 1'b1; sync = 1'b1; div_load = 1'b1; div_int = 16'd50; cyc();
      reset = 1'b0; sync = 1'b0; div_load = 1'b0;
      chk("midreset_q", q, 0);
      wait_tick(400, n);
      chk("midreset_default_gap", n, DIV_RST);

      // random enable, sync and load traffic with small divisors
      sync = 1'b1; cyc(); sync = 1'b0;
      for (int it = 0; it < 80; it++) begin
         en       = ($urandom_range(0, 4) != 0);
         sync     = ($urandom_range(0, 7) == 0);
         div_load = ($urandom_range(0, 2) == 0);
         div_int  = N'($urandom_range(0, 24));
         div_frac = F'($urandom_range(0, 15));
         cyc();
         sync = 1'b0; div_load = 1'b0;
         repeat ($urandom_range(1, 30)) cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
